aes_inv_cipher: RTL and testbench

- Iterative AES inverse cipher (FIPS-197 Sec. 5.3) that decrypts one 128-bit block.
- Performs one round per clock with a single shared round datapath, under valid/ready handshakes on input and output.
- Sits on the decrypt side of the AES datapath, fed by the same expanded round-key array the key schedule produces.
- Builds on aes_pkg: InvSubBytes, InvShiftRows and InvMixColumns are added there alongside AddRoundKey.

---
 rtl/aes_inv_cipher_if.sv | 19 +
 rtl/aes_inv_cipher.sv | 153 +++++++++++++++
 tb/tb_aes_inv_cipher.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_inv_cipher_if.sv
// rtl/aes_inv_cipher_if.sv - ciphertext-in / plaintext-out handshake bundle for aes_inv_cipher
interface aes_inv_cipher_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] ct;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] pt;

  modport master (
    output in_valid, ct, out_ready,
    input  in_ready, out_valid, pt
  );

  modport slave (
    input  in_valid, ct, out_ready,
    output in_ready, out_valid, pt
  );
endinterface

// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - AES round helpers and iterative one-round-per-clock inverse cipher
// State byte i (FIPS input order) lives at bits [8i+7:8i], i.e. st[col][row] = byte 4*col+row.
package aes_pkg;
  typedef logic [3:0][3:0][7:0] state_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] x;
    r = 8'h01;
    x = a;
    for (int i = 1; i < 8; i++) begin
      x = gf_mul(x, x);
      r = gf_mul(r, x);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] s);
    logic [7:0] b;
    b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
    return gf_inv(b);
  endfunction

  function automatic state_t inv_shift_rows(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = s[(c + 4 - r) % 4][r];
    return o;
  endfunction

  function automatic state_t inv_sub_bytes(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = inv_sbox(s[c][r]);
    return o;
  endfunction

  function automatic state_t inv_mix_columns(input state_t s);
    state_t o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[c][r] = gf_mul(s[c][r], 8'h0e) ^ gf_mul(s[c][(r + 1) % 4], 8'h0b) ^
                  gf_mul(s[c][(r + 2) % 4], 8'h0d) ^ gf_mul(s[c][(r + 3) % 4], 8'h09);
    return o;
  endfunction

  function automatic state_t add_round_key(input state_t s, input state_t k);
    return s ^ k;
  endfunction
endpackage

module aes_inv_cipher
  import aes_pkg::*;
#(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic                        clk,
  input  logic                        rst,
  aes_inv_cipher_if.slave             bus,
  input  logic [4*(Nr+1)-1:0][31:0]   rkey
);
  localparam int RW = $clog2(Nr);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  fsm_e          fsm_q, fsm_d;
  state_t        state_q, state_d;
  logic [RW-1:0] rnd_q, rnd_d;

  logic   in_ready;
  logic   accept;
  state_t rk_cur;
  state_t rk_last;
  state_t round_out;

  assign rk_cur    = rkey[4*int'(rnd_q) +: 4];
  assign rk_last   = rkey[4*Nr +: 4];
  assign round_out = add_round_key(inv_sub_bytes(inv_shift_rows(state_q)), rk_cur);

  assign in_ready = !rst && ((fsm_q == IDLE) || ((fsm_q == DONE) && bus.out_ready));
  assign accept   = bus.in_valid && in_ready;

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    case (fsm_q)
      IDLE: begin
        if (accept) begin
          state_d = add_round_key(bus.ct, rk_last);
          rnd_d   = RW'(Nr - 1);
          fsm_d   = RUN;
        end
      end
      RUN: begin
        if (rnd_q != '0) begin
          state_d = inv_mix_columns(round_out);
          rnd_d   = rnd_q - RW'(1);
        end else begin
          state_d = round_out;
          fsm_d   = DONE;
        end
      end
      DONE: begin
        // A waiting block is loaded on the same edge the plaintext leaves.
        if (accept) begin
          state_d = add_round_key(bus.ct, rk_last);
          rnd_d   = RW'(Nr - 1);
          fsm_d   = RUN;
        end else if (bus.out_ready) begin
          fsm_d = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (fsm_q == DONE);
  assign bus.pt        = state_q;
endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb/tb_aes_inv_cipher.sv - directed FIPS-197 appendix C decrypt checks for aes_inv_cipher
module tb_aes_inv_cipher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_inv_cipher_if b4 ();
  aes_inv_cipher_if b6 ();
  aes_inv_cipher_if b8 ();

  logic [43:0][31:0] rk4;
  logic [51:0][31:0] rk6;
  logic [59:0][31:0] rk8;

  aes_inv_cipher #(.Nk(4)) u4 (.clk(clk), .rst(rst), .bus(b4), .rkey(rk4));
  aes_inv_cipher #(.Nk(6)) u6 (.clk(clk), .rst(rst), .bus(b6), .rkey(rk6));
  aes_inv_cipher #(.Nk(8)) u8 (.clk(clk), .rst(rst), .bus(b8), .rkey(rk8));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_sbox(input logic [7:0] x);
    logic [7:0] v = 8'h00;
    for (int y = 1; y < 256; y++)
      if (tb_mul(x, 8'(y)) == 8'h01) v = 8'(y);
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {tb_sbox(t[31:24]), tb_sbox(t[23:16]), tb_sbox(t[15:8]), tb_sbox(t[7:0])};
  endfunction

  // key holds FIPS-order bytes left-aligned; word bytes are row-at-bit-8*row.
  function automatic logic [59:0][31:0] expand(input int nk, input logic [255:0] key);
    logic [59:0][31:0] w  = '0;
    logic [31:0]       t;
    logic [7:0]        rc = 8'h01;
    for (int i = 0; i < nk; i++)
      for (int b = 0; b < 4; b++)
        w[i][8*b +: 8] = key[255 - 8*(4*i + b) -: 8];
    for (int i = nk; i < 4*(nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = sub_word({t[7:0], t[31:8]}) ^ {24'h0, rc};
        rc = tb_mul(rc, 8'h02);
      end else if (nk > 6 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return w;
  endfunction

  function automatic logic [127:0] fips(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[127 - 8*i -: 8];
    return y;
  endfunction

  task automatic set_in(input int nk, input logic v, input logic [127:0] c);
    case (nk)
      4: begin b4.in_valid = v; b4.ct = c; end
      6: begin b6.in_valid = v; b6.ct = c; end
      default: begin b8.in_valid = v; b8.ct = c; end
    endcase
  endtask

  function automatic logic ov(input int nk);
    return (nk == 4) ? b4.out_valid : (nk == 6) ? b6.out_valid : b8.out_valid;
  endfunction

  function automatic logic ir(input int nk);
    return (nk == 4) ? b4.in_ready : (nk == 6) ? b6.in_ready : b8.in_ready;
  endfunction

  function automatic logic [127:0] ptv(input int nk);
    return (nk == 4) ? b4.pt : (nk == 6) ? b6.pt : b8.pt;
  endfunction

  task automatic start(input int nk, input logic [127:0] c, input string tag);
    @(posedge clk); #1 set_in(nk, 1'b1, c);
    @(negedge clk); check({tag, "_in_ready"}, 128'(ir(nk)), 128'd1);
    @(posedge clk); #1 set_in(nk, 1'b0, '0);
  endtask

  // Returns how many edges after the accept edge out_valid was first seen, or -1.
  task automatic wait_out(input int nk, input int max, output int lat);
    lat = -1;
    for (int k = 0; k <= max; k++) begin
      @(negedge clk);
      if (ov(nk)) begin
        lat = k;
        break;
      end
    end
  endtask

  logic [127:0] ct128, ct192, ct256, pt_exp;
  int lat;
  int seen;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [59:0][31:0] w;
    ct128  = fips(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    ct192  = fips(128'hdda97ca4864cdfe06eaf70a0ec0d7191);
    ct256  = fips(128'h8ea2b7ca516745bfeafc49904b496089);
    pt_exp = fips(128'h00112233445566778899aabbccddeeff);
    w   = expand(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
    rk4 = w[43:0];
    w   = expand(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
    rk6 = w[51:0];
    w   = expand(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    rk8 = w;
    set_in(4, 1'b0, '0); set_in(6, 1'b0, '0); set_in(8, 1'b0, '0);
    b4.out_ready = 1'b1; b6.out_ready = 1'b1; b8.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(b4.out_valid), 128'd0);
    check("rst_in_ready", 128'(b4.in_ready), 128'd0);
    check("rst_pt", b4.pt, 128'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 128'(b4.in_ready), 128'd1);

    // AES-128/192/256 single blocks
    start(4, ct128, "c1");
    wait_out(4, 40, lat);
    check("c1_latency", 128'(lat), 128'd10);
    check("c1_pt", b4.pt, pt_exp);
    @(negedge clk);
    check("c1_valid_one_cycle", 128'(b4.out_valid), 128'd0);
    start(6, ct192, "c2");
    wait_out(6, 40, lat);
    check("c2_latency", 128'(lat), 128'd12);
    check("c2_pt", b6.pt, pt_exp);
    start(8, ct256, "c3");
    wait_out(8, 40, lat);
    check("c3_latency", 128'(lat), 128'd14);
    check("c3_pt", b8.pt, pt_exp);

    // Backpressure with ignored in_valid pulses
    b4.out_ready = 1'b0;
    start(4, ct128, "bp");
    wait_out(4, 40, lat);
    check("bp_latency", 128'(lat), 128'd10);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1 set_in(4, 1'(i % 2), 128'hdeadbeef0badf00d ^ 128'(i));
      @(negedge clk);
      check("bp_out_valid", 128'(b4.out_valid), 128'd1);
      check("bp_pt", b4.pt, pt_exp);
      check("bp_in_ready", 128'(b4.in_ready), 128'd0);
    end
    @(posedge clk); #1 set_in(4, 1'b0, '0); b4.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_in_ready", 128'(b4.in_ready), 128'd1);
    check("bp_release_valid", 128'(b4.out_valid), 128'd1);
    @(posedge clk); #1 b4.out_ready = 1'b0;
    @(negedge clk);
    check("bp_idle_valid", 128'(b4.out_valid), 128'd0);
    check("bp_idle_in_ready", 128'(b4.in_ready), 128'd1);
    check("bp_idle_pt_held", b4.pt, pt_exp);
    b4.out_ready = 1'b1;

    // Back-to-back with in_valid held high
    @(posedge clk); #1 set_in(4, 1'b1, ct128);
    @(posedge clk);
    wait_out(4, 40, lat);
    check("b2b_first_latency", 128'(lat), 128'd10);
    check("b2b_first_pt", b4.pt, pt_exp);
    check("b2b_in_ready", 128'(b4.in_ready), 128'd1);
    @(posedge clk); #1 set_in(4, 1'b0, '0);
    wait_out(4, 40, lat);
    check("b2b_second_latency", 128'(lat), 128'd10);
    check("b2b_second_pt", b4.pt, pt_exp);
    @(negedge clk);
    check("b2b_done_valid", 128'(b4.out_valid), 128'd0);

    // Reset during rnd=5
    start(4, ct128, "mr");
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mr_out_valid", 128'(b4.out_valid), 128'd0);
    check("mr_in_ready", 128'(b4.in_ready), 128'd1);
    check("mr_pt", b4.pt, 128'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (b4.out_valid) seen++;
    end
    check("mr_aborted_block", 128'(seen), 128'd0);
    start(4, ct128, "mr_fresh");
    wait_out(4, 40, lat);
    check("mr_fresh_latency", 128'(lat), 128'd10);
    check("mr_fresh_pt", b4.pt, pt_exp);

    // Reset coincident with an accept
    @(posedge clk); #1 rst = 1'b1; set_in(4, 1'b1, ct128);
    @(negedge clk);
    check("ra_in_ready_rst", 128'(b4.in_ready), 128'd0);
    @(posedge clk); #1 rst = 1'b0; set_in(4, 1'b0, '0); b4.out_ready = 1'b0;
    @(negedge clk);
    check("ra_idle_in_ready", 128'(b4.in_ready), 128'd1);
    check("ra_pt", b4.pt, 128'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (b4.out_valid) seen++;
    end
    check("ra_no_output", 128'(seen), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
